moore_run_detector: RTL and testbench

- Parametrised Moore sequence detector: asserts z once input w has matched a selectable target bit on RUN_LEN consecutive enabled clock edges.
- Generalises the fixed two-ones detector with several additions:
  - configurable run length;
  - selectable target polarity;
  - sample enable;
  - overlapping or re-arming (non-overlapping) detection;
  - detection pulse and saturating event counter.
- Sits between input conditioning logic and status/counter readout in lab-level designs.

---
 rtl/moore_run_detector_pkg.sv | 10 +
 rtl/sat_counter.sv | 29 ++
 rtl/moore_run_detector.sv | 107 ++++++++++
 tb/tb_moore_run_detector.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/moore_run_detector_pkg.sv
// Shared encodings for the run detector FSM.
package moore_run_detector_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] IDLE   = 2'b00;
  localparam logic [StateW-1:0] RUN    = 2'b01;
  localparam logic [StateW-1:0] DETECT = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter
  import moore_run_detector_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Clear wins over a simultaneous increment.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/moore_run_detector.sv
// Moore detector: z asserts once w has matched target on RUN_LEN consecutive enabled edges.
module moore_run_detector
  import moore_run_detector_pkg::*;
#(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en,
  input  logic             w,
  input  logic             target,
  input  logic             rearm,
  input  logic             clr_count,
  output logic             z,
  output logic             det_pulse,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] det_count
);

  localparam logic [RUN_W-1:0]  RunOne  = RUN_W'(1);
  localparam logic [RUN_W-1:0]  RunMax  = RUN_W'(RUN_LEN);
  // A single match already completes a run when RUN_LEN is 1.
  localparam logic [StateW-1:0] FirstSt = (RUN_LEN == 1) ? DETECT : RUN;

  logic [StateW-1:0] state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              det_pulse_q;
  logic              det_event;
  logic              match;

  assign match = (w == target);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (match) begin
            state_d = FirstSt;
            run_d   = RunOne;
          end else begin
            run_d = '0;
          end
        end
      end
      RUN: begin
        if (en) begin
          if (match) begin
            run_d = run_q + RunOne;
            if (run_d == RunMax) state_d = DETECT;
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
      end
      DETECT: begin
        if (en) begin
          if (!match) begin
            state_d = IDLE;
            run_d   = '0;
          end else if (rearm) begin
            state_d = FirstSt;
            run_d   = RunOne;
          end
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Entering DETECT, or re-detecting in place when re-arming with RUN_LEN of 1.
  assign det_event = en && (state_d == DETECT) && ((state_q != DETECT) || rearm);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      run_q       <= '0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      det_pulse_q <= det_event;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_det_count (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (clr_count),
    .inc    (det_event),
    .q      (det_count)
  );

  assign z         = (state_q == DETECT);
  assign det_pulse = det_pulse_q;
  assign run_len   = run_q;

endmodule

// File: tb/tb_moore_run_detector.sv
// Scoreboard bench: two detectors (RUN_LEN 3 and 1) share stimulus and are checked against a streak model.
module tb_moore_run_detector;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn = 1'b0, en = 1'b0, w = 1'b0, target = 1'b1, rearm = 1'b0, clr_count = 1'b0;

  logic       z3, p3, z1, p1;
  logic [1:0] r3;
  logic [0:0] r1;
  logic [3:0] c3, c1;

  moore_run_detector #(.RUN_LEN(3), .CNT_W(4)) dut3 (
    .Clock (Clock), .Resetn (Resetn), .en (en), .w (w), .target (target), .rearm (rearm),
    .clr_count (clr_count), .z (z3), .det_pulse (p3), .run_len (r3), .det_count (c3)
  );

  moore_run_detector #(.RUN_LEN(1), .CNT_W(4)) dut1 (
    .Clock (Clock), .Resetn (Resetn), .en (en), .w (w), .target (target), .rearm (rearm),
    .clr_count (clr_count), .z (z1), .det_pulse (p1), .run_len (r1), .det_count (c1)
  );

  typedef struct {
    int z[2];
    int p[2];
    int r[2];
    int c[2];
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: streak of consecutive matches since the last restart.
  int   len[2] = '{3, 1};
  int   streak[2];
  bit   zf[2];
  bit   pul[2];
  int   cnt[2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!Resetn) begin
        streak[k] = 0; zf[k] = 0; pul[k] = 0; cnt[k] = 0;
      end else begin
        bit ev = 0;
        if (en) begin
          bit zn;
          if (w != target) begin
            streak[k] = 0;
            zn = 0;
          end else begin
            streak[k] = (zf[k] && rearm) ? 1 : streak[k] + 1;
            zn = (streak[k] >= len[k]);
            ev = zn && (!zf[k] || rearm);
          end
          zf[k] = zn;
        end
        pul[k] = ev;
        if (clr_count) cnt[k] = 0;
        else if (ev && cnt[k] < 15) cnt[k]++;
      end
    end
  endtask

  task automatic step(input bit e, input bit ww, input bit tg, input bit ra, input bit cl,
                      input bit rn);
    exp_t x;
    en = e; w = ww; target = tg; rearm = ra; clr_count = cl; Resetn = rn;
    @(posedge Clock);
    model_edge();
    for (int k = 0; k < 2; k++) begin
      x.z[k] = zf[k];
      x.p[k] = pul[k];
      x.r[k] = (streak[k] < len[k]) ? streak[k] : len[k];
      x.c[k] = cnt[k];
    end
    q.push_back(x);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so compare 1 time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("z_len3",         32'(z3), e.z[0]);
        chk("det_pulse_len3", 32'(p3), e.p[0]);
        chk("run_len_len3",   32'(r3), e.r[0]);
        chk("det_count_len3", 32'(c3), e.c[0]);
        chk("z_len1",         32'(z1), e.z[1]);
        chk("det_pulse_len1", 32'(p1), e.p[1]);
        chk("run_len_len1",   32'(r1), e.r[1]);
        chk("det_count_len1", 32'(c1), e.c[1]);
      end
    end
  end

  initial begin
    // 1: overlapping run of five ones
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 1);
    // 2: re-arming, six ones
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, 1);
    // 3: broken run, then target=0
    step(1, 0, 1, 0, 0, 0);
    begin
      bit [5:0] pat = 6'b111011;
      for (int i = 5; i >= 0; i--) step(1, pat[i], 1, 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    // 4: enable gap holds run_len
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    // 5: saturation (RUN_LEN=1 instance), then clear on a detection edge
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 0, 1);
    // 6: reset while in DETECT, then a glitch between edges only
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1);
    Resetn = 1'b0;
    #3;
    Resetn = 1'b1;
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e  = ($urandom_range(0, 9) != 0);
      bit ww = ($urandom_range(0, 3) != 0);
      bit tg = ($urandom_range(0, 15) != 0);
      bit ra = $urandom_range(0, 1);
      bit cl = ($urandom_range(0, 19) == 0);
      bit rn = ($urandom_range(0, 49) != 0);
      if (!tg) ww = ~ww;
      step(e, ww, tg, ra, cl, rn);
    end
    // Drain the scoreboard
    repeat (3) @(posedge Clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
